// File: rtl/sl_transmitter.sv
// sl_transmitter: serialises the low N bits of a 32-bit word, LSB first, onto
// the SL zeroes/ones line pair. Each frame is N bit slots, then a gap, a
// parity slot, a post-parity idle, a sync (both-low) slot and a short tail.
// Every slot is built from phases of PHASE_CYCLES clocks.
//
// Optional feature: define SL_TX_PARITY_INJECT_EN to store config bit [7].
// A frame started with that bit set sends inverted parity. When the macro is
// undefined, bit [7] is forced to 0 and parity is always correct.
//
// Host strobes: wr_enable and wr_data are single-cycle strobes with no
// back-pressure. A wr_data that arrives while busy is dropped and flagged in
// the sticky overrun bit.
module sl_transmitter #(
    parameter int PHASE_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_enable,
    input  logic [15:0] wr_config_w,
    output logic [15:0] r_config_w,
    input  logic        wr_data,
    input  logic [31:0] data_w,
    output logic [15:0] status_w,
    output logic        tx_done,
    output logic        serial_line_zeroes,
    output logic        serial_line_ones
);

    localparam int PW = $clog2(2 * PHASE_CYCLES) > 0 ? $clog2(2 * PHASE_CYCLES) : 1;
    localparam logic [PW-1:0] Q_LAST  = PW'(PHASE_CYCLES - 1);
    localparam logic [PW-1:0] Q2_LAST = PW'(2 * PHASE_CYCLES - 1);

`ifdef SL_TX_PARITY_INJECT_EN
    localparam logic [15:0] CFG_MASK = 16'h00FF;
`else
    localparam logic [15:0] CFG_MASK = 16'h007F;
`endif

    // A bit slot is split into its three level phases (pre, low, post).
    typedef enum logic [3:0] {
        S_IDLE,
        S_BIT_PRE,
        S_BIT_LOW,
        S_BIT_POST,
        S_GAP,
        S_PAR,
        S_POST,
        S_SYNC,
        S_TAIL
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] cnt_q, cnt_d;
    logic [5:0]    bit_q, bit_d;
    logic [31:0]   data_q, data_d;
    logic [5:0]    n_q, n_d;
    logic          inv_q, inv_d;
    logic          par0_q, par0_d;
    logic          par1_q, par1_d;
    logic [15:0]   cfg_q, cfg_d;
    logic          ovr_q, ovr_d;
    logic          cerr_q, cerr_d;
    logic          done_q, done_d;
    logic          tx_done_q, tx_done_d;
    logic          zeroes_q, zeroes_d;
    logic          ones_q, ones_d;

    logic [5:0]    cfg_n;
    logic          cfg_ok;
    logic          cur_bit;
    logic          next_bit;

    assign cfg_n  = wr_config_w[6:1];
    assign cfg_ok = !cfg_n[0] && (cfg_n >= 6'd8) && (cfg_n <= 6'd32);

    assign r_config_w         = cfg_q;
    assign status_w           = {12'd0, done_q, cerr_q, ovr_q, (state_q != S_IDLE)};
    assign tx_done            = tx_done_q;
    assign serial_line_zeroes = zeroes_q;
    assign serial_line_ones   = ones_q;

    // Register file: FSM state, counters, frame latches, status and output levels.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            data_q    <= '0;
            n_q       <= '0;
            inv_q     <= 1'b0;
            par0_q    <= 1'b1;
            par1_q    <= 1'b0;
            cfg_q     <= 16'h0040;
            ovr_q     <= 1'b0;
            cerr_q    <= 1'b0;
            done_q    <= 1'b0;
            tx_done_q <= 1'b0;
            zeroes_q  <= 1'b1;
            ones_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            data_q    <= data_d;
            n_q       <= n_d;
            inv_q     <= inv_d;
            par0_q    <= par0_d;
            par1_q    <= par1_d;
            cfg_q     <= cfg_d;
            ovr_q     <= ovr_d;
            cerr_q    <= cerr_d;
            done_q    <= done_d;
            tx_done_q <= tx_done_d;
            zeroes_q  <= zeroes_d;
            ones_q    <= ones_d;
        end
    end

    // Next state: config writes first, so a same-cycle frame start sees the new config.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        data_d  = data_q;
        n_d     = n_q;
        inv_d   = inv_q;
        par0_d  = par0_q;
        par1_d  = par1_q;
        cfg_d   = cfg_q;
        ovr_d   = ovr_q;
        cerr_d  = cerr_q;
        done_d  = done_q;
        cur_bit = data_q[bit_q[4:0]];

        if (wr_enable) begin
            if (cfg_ok) begin
                cfg_d  = wr_config_w & CFG_MASK;
                ovr_d  = 1'b0;
                cerr_d = 1'b0;
                done_d = 1'b0;
            end else begin
                cerr_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (wr_data) begin
                    state_d = S_BIT_PRE;
                    data_d  = data_w;
                    n_d     = cfg_d[6:1];
                    inv_d   = cfg_d[7];
                    bit_d   = '0;
                    par0_d  = 1'b1;
                    par1_d  = 1'b0;
                    done_d  = 1'b0;
                end
            end
            S_BIT_PRE: begin
                if (cnt_q == Q_LAST) begin
                    state_d = S_BIT_LOW;
                    cnt_d   = '0;
                end
            end
            S_BIT_LOW: begin
                if (cnt_q == Q2_LAST) begin
                    state_d = S_BIT_POST;
                    cnt_d   = '0;
                end
            end
            S_BIT_POST: begin
                if (cnt_q == Q_LAST) begin
                    cnt_d = '0;
                    if (cur_bit) begin
                        par1_d = ~par1_q;
                    end else begin
                        par0_d = ~par0_q;
                    end
                    if (bit_q == n_q - 6'd1) begin
                        state_d = S_GAP;
                    end else begin
                        bit_d   = bit_q + 6'd1;
                        state_d = S_BIT_PRE;
                    end
                end
            end
            S_GAP: begin
                if (cnt_q == Q_LAST) begin
                    state_d = S_PAR;
                    cnt_d   = '0;
                end
            end
            S_PAR: begin
                if (cnt_q == Q2_LAST) begin
                    state_d = S_POST;
                    cnt_d   = '0;
                end
            end
            S_POST: begin
                if (cnt_q == Q2_LAST) begin
                    state_d = S_SYNC;
                    cnt_d   = '0;
                end
            end
            S_SYNC: begin
                if (cnt_q == Q2_LAST) begin
                    state_d = S_TAIL;
                    cnt_d   = '0;
                end
            end
            S_TAIL: begin
                if (cnt_q == Q_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (wr_data && (state_q != S_IDLE)) begin
            ovr_d = 1'b1;
        end
    end

    // Output levels are decoded from the next state so the registered lines line up with state_q.
    always_comb begin
        zeroes_d  = 1'b1;
        ones_d    = 1'b1;
        next_bit  = data_d[bit_d[4:0]];
        tx_done_d = (state_d == S_TAIL) && (cnt_d == Q_LAST);
        case (state_d)
            S_BIT_LOW: begin
                zeroes_d = next_bit;
                ones_d   = ~next_bit;
            end
            S_PAR: begin
                zeroes_d = par0_d ^ inv_d;
                ones_d   = par1_d ^ inv_d;
            end
            S_SYNC: begin
                zeroes_d = 1'b0;
                ones_d   = 1'b0;
            end
            default: begin
                zeroes_d = 1'b1;
                ones_d   = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_sl_transmitter.sv
// Testbench for sl_transmitter: randomized frames checked cycle by cycle
// against a frame-level model that expands each frame into its expected
// {tx_done, busy, zeroes, ones} sequence.
module tb_sl_transmitter;

    localparam int Q = 8;

`ifdef SL_TX_PARITY_INJECT_EN
    localparam logic [15:0] CFG_MASK = 16'h00FF;
`else
    localparam logic [15:0] CFG_MASK = 16'h007F;
`endif

    // Clock and reset
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_enable = 1'b0;
    logic [15:0] wr_config_w = '0;
    logic [15:0] r_config_w;
    logic        wr_data = 1'b0;
    logic [31:0] data_w = '0;
    logic [15:0] status_w;
    logic        tx_done;
    logic        serial_line_zeroes;
    logic        serial_line_ones;

    always #5 clk = ~clk;

    sl_transmitter #(.PHASE_CYCLES(Q)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .wr_enable          (wr_enable),
        .wr_config_w        (wr_config_w),
        .r_config_w         (r_config_w),
        .wr_data            (wr_data),
        .data_w             (data_w),
        .status_w           (status_w),
        .tx_done            (tx_done),
        .serial_line_zeroes (serial_line_zeroes),
        .serial_line_ones   (serial_line_ones)
    );

    // Scoreboard state
    int          n_cmp = 0;
    int          n_err = 0;
    logic [3:0]  exp_q[$];
    logic [15:0] m_cfg = 16'h0040;
    logic        m_ovr = 1'b0;
    logic        m_cerr = 1'b0;
    logic        m_done = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: config register and sticky flags
    function automatic void model_cfg(input logic [15:0] v);
        int n;
        n = int'(v[6:1]);
        if ((n % 2 == 0) && n >= 8 && n <= 32) begin
            m_cfg  = v & CFG_MASK;
            m_ovr  = 1'b0;
            m_cerr = 1'b0;
            m_done = 1'b0;
        end else begin
            m_cerr = 1'b1;
        end
    endfunction

    function automatic logic [15:0] exp_status_idle();
        return {12'd0, m_done, m_cerr, m_ovr, 1'b0};
    endfunction

    // Reference model: whole-frame line sequence, entries are {tx_done, busy, zeroes, ones}
    function automatic void build_frame(input logic [31:0] d, input int n, input logic inv);
        int   zc;
        int   oc;
        logic b;
        logic p0;
        logic p1;
        zc = 0;
        oc = 0;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            b = d[i];
            if (b) oc++; else zc++;
            repeat (Q)     exp_q.push_back(4'b0111);
            repeat (2 * Q) exp_q.push_back({2'b01, b, ~b});
            repeat (Q)     exp_q.push_back(4'b0111);
        end
        p0 = 1'b1 ^ (zc % 2 == 1) ^ inv;
        p1 = (oc % 2 == 1) ^ inv;
        repeat (Q)     exp_q.push_back(4'b0111);
        repeat (2 * Q) exp_q.push_back({2'b01, p0, p1});
        repeat (2 * Q) exp_q.push_back(4'b0111);
        repeat (2 * Q) exp_q.push_back(4'b0100);
        repeat (Q - 1) exp_q.push_back(4'b0111);
        exp_q.push_back(4'b1111);
    endfunction

    // Driver: config write, called and returning at a negedge
    task automatic write_cfg(input logic [15:0] v);
        wr_enable   = 1'b1;
        wr_config_w = v;
        @(negedge clk);
        wr_enable = 1'b0;
        model_cfg(v);
        check_val("r_config", {16'd0, r_config_w}, {16'd0, m_cfg});
        check_val("cfg_status", {16'd0, status_w}, {16'd0, exp_status_idle()});
    endtask

    // Driver: one frame, optionally with a same-cycle config, a mid-frame
    // wr_data pulse (ovr_at) and a mid-frame config write (cfgw_at).
    task automatic run_frame(input logic [31:0] d, input bit with_cfg, input logic [15:0] cfg_v,
                             input int ovr_at, input int cfgw_at, input logic [15:0] cfgw_v);
        int   total;
        int   n;
        logic inv;
        logic [3:0] obs;
        if (with_cfg) begin
            model_cfg(cfg_v);
            wr_enable   = 1'b1;
            wr_config_w = cfg_v;
        end
        n   = int'(m_cfg[6:1]);
        inv = m_cfg[7];
        build_frame(d, n, inv);
        total  = exp_q.size();
        m_done = 1'b0;
        wr_data = 1'b1;
        data_w  = d;
        @(negedge clk);
        wr_enable = 1'b0;
        for (int i = 0; i < total; i++) begin
            obs = {tx_done, status_w[0], serial_line_zeroes, serial_line_ones};
            check_val($sformatf("frame[%0d]", i), {28'd0, obs}, {28'd0, exp_q.pop_front()});
            if (i == ovr_at) begin
                wr_data = 1'b1;
                data_w  = $urandom;
                m_ovr   = 1'b1;
            end else begin
                wr_data = 1'b0;
            end
            if (i == cfgw_at) begin
                wr_enable   = 1'b1;
                wr_config_w = cfgw_v;
                model_cfg(cfgw_v);
            end else begin
                wr_enable = 1'b0;
            end
            @(negedge clk);
        end
        m_done = 1'b1;
        check_val("post_lines", {28'd0, tx_done, status_w[0], serial_line_zeroes, serial_line_ones},
                  32'h3);
        check_val("post_status", {16'd0, status_w}, {16'd0, exp_status_idle()});
        check_val("post_config", {16'd0, r_config_w}, {16'd0, m_cfg});
    endtask

    function automatic logic [15:0] rand_valid_cfg();
        logic [15:0] v;
        v      = 16'($urandom);
        v[6:1] = 6'(2 * $urandom_range(4, 8));
        return v;
    endfunction

    initial begin
        int          k;
        logic [15:0] v;
        // Reset
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_val("rst_config", {16'd0, r_config_w}, 32'h0040);
        check_val("rst_status", {16'd0, status_w}, 32'h0);
        check_val("rst_lines", {28'd0, tx_done, status_w[0], serial_line_zeroes, serial_line_ones}, 32'h3);
        @(negedge clk);

        // N=8, data A5
        write_cfg(16'h0010);
        run_frame(32'h0000_00A5, 1'b0, 16'h0, -1, -1, 16'h0);
        check_val("a5_status", {16'd0, status_w}, 32'h0008);

        // N=32, all zeroes: 1088-cycle frame
        write_cfg(16'h0040);
        run_frame(32'h0000_0000, 1'b0, 16'h0, -1, -1, 16'h0);

        // Overrun plus a config write mid-frame; frame must be unaltered
        write_cfg(16'h0018);
        k = $urandom_range(20, 150);
        run_frame($urandom, 1'b0, 16'h0, k + 40, k, 16'h0014);
        check_val("ovr_flag", {31'd0, status_w[1]}, 32'h1);
        write_cfg(16'h0010);
        check_val("ovr_cleared", {31'd0, status_w[1]}, 32'h0);

        // Invalid lengths leave config untouched and set the error flag
        write_cfg(16'h000E);
        write_cfg(16'h0044);
        write_cfg(16'h000C);
        write_cfg(16'h0003);
        check_val("cerr_flag", {31'd0, status_w[2]}, 32'h1);
        run_frame($urandom, 1'b0, 16'h0, -1, -1, 16'h0);
        write_cfg(16'h0015);

        // Same-cycle config and data in IDLE
        run_frame($urandom, 1'b1, rand_valid_cfg(), -1, -1, 16'h0);
        run_frame($urandom, 1'b1, 16'h0046, -1, -1, 16'h0);

        // Random frames, back to back
        for (int f = 0; f < 5; f++) begin
            v = rand_valid_cfg();
            if ($urandom_range(0, 1) == 1) begin
                run_frame($urandom, 1'b1, v, -1, -1, 16'h0);
            end else begin
                write_cfg(v);
                run_frame($urandom, 1'b0, 16'h0, -1, -1, 16'h0);
            end
        end

        // Reset during a bit slot
        write_cfg(16'h0020);
        wr_data = 1'b1;
        data_w  = $urandom;
        @(negedge clk);
        wr_data = 1'b0;
        repeat ($urandom_range(Q + 1, 12 * Q)) @(negedge clk);
        check_val("pre_rst_busy", {31'd0, status_w[0]}, 32'h1);
        rst_n = 1'b0;
        @(negedge clk);
        m_cfg = 16'h0040; m_ovr = 1'b0; m_cerr = 1'b0; m_done = 1'b0;
        check_val("midrst_lines", {28'd0, tx_done, status_w[0], serial_line_zeroes, serial_line_ones}, 32'h3);
        check_val("midrst_status", {16'd0, status_w}, 32'h0);
        check_val("midrst_config", {16'd0, r_config_w}, 32'h0040);
        rst_n = 1'b1;
        for (int i = 0; i < 4 * Q * 3; i++) begin
            @(negedge clk);
            check_val("post_rst_idle", {28'd0, tx_done, status_w[0], serial_line_zeroes, serial_line_ones}, 32'h3);
        end

        // Parity inject config (inverted only when the feature is built in)
        write_cfg(16'h0091);
        run_frame(32'h0000_00FF, 1'b0, 16'h0, -1, -1, 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
